crc_check: RTL

- Receive-side counterpart of the CRC generator. Accepts a 136-bit codeword: 128 data bits, then an 8-bit CRC in the low bits.
- Recomputes the CRC over the data field iteratively, STEP bits per cycle, and compares it with the received CRC.
- Returns the data field together with a pass/fail flag.
- Sits on the receive path of links protected by the generator; uses the same valid/busy/valid handshake style.

---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_step.sv | 23 ++
 rtl/crc_check.sv | 89 ++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-8 constants, types and the one-bit update step
package crc_pkg;

  localparam int CRC_W = 8;

  typedef logic [CRC_W-1:0] crc_t;

  localparam crc_t POLY = 8'h07;
  localparam crc_t INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Non-reflected shift: the bit leaving the MSB decides whether POLY is folded in.
  function automatic crc_t crcBit(input crc_t crc, input logic b, input crc_t poly = POLY);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return (crc << 1) ^ (fb ? poly : '0);
  endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational STEP-bit CRC update, MSB of data first
module crc_step
  import crc_pkg::*;
#(
  parameter int   STEP = 8,
  parameter crc_t POLY = crc_pkg::POLY
) (
  input  crc_t            crc,
  input  logic [STEP-1:0] data,
  output crc_t            next_crc
);

  crc_t acc;

  always_comb begin
    acc = crc;
    for (int i = STEP - 1; i >= 0; i--) begin
      acc = crcBit(acc, data[i], POLY);
    end
    next_crc = acc;
  end

endmodule

// File: rtl/crc_check.sv
// rtl/crc_check.sv - iterative receive-side CRC checker returning data plus pass flag
module crc_check
  import crc_pkg::*;
#(
  parameter int   DATA_W = 128,
  parameter int   CRC_W  = crc_pkg::CRC_W,
  parameter crc_t POLY   = crc_pkg::POLY,
  parameter crc_t INIT   = crc_pkg::INIT,
  parameter int   STEP   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inDataValid_i,
  input  logic [DATA_W+CRC_W-1:0] inData_i,
  output logic                    busy_o,
  output logic [DATA_W-1:0]       outData_o,
  output logic                    outValid_o,
  output logic                    crcOk_o
);

  localparam int STEPS = DATA_W / STEP;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  data_q;
  crc_t               crc_q;
  crc_t               crc_rx;
  crc_t               crc_next;

  crc_step #(
    .STEP (STEP),
    .POLY (POLY)
  ) u_step (
    .crc      (crc_q),
    .data     (shift_q[DATA_W-1 -: STEP]),
    .next_crc (crc_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      count      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      crc_q      <= INIT;
      crc_rx     <= '0;
      busy_o     <= 1'b0;
      outData_o  <= '0;
      outValid_o <= 1'b0;
      crcOk_o    <= 1'b0;
    end else begin
      outValid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (inDataValid_i) begin
            shift_q <= inData_i[DATA_W+CRC_W-1:CRC_W];
            data_q  <= inData_i[DATA_W+CRC_W-1:CRC_W];
            crc_rx  <= inData_i[CRC_W-1:0];
            crc_q   <= INIT;
            count   <= '0;
            busy_o  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          crc_q   <= crc_next;
          shift_q <= shift_q << STEP;
          count   <= count + 1'b1;
          // Final step: compare the just-computed CRC, not the stale register.
          if (count == LAST) begin
            state      <= DONE;
            outValid_o <= 1'b1;
            outData_o  <= data_q;
            crcOk_o    <= (crc_next == crc_rx);
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
